mem_bank_rw: RTL and testbench

Parametrised single-port register-file memory, successor to the fixed 4x16 test memory. Adds configurable width/depth, byte-lane write strobes, registered read path with configurable latency and valid flag, out-of-range error reporting, and a sequential soft-clear engine with busy indication. Sits behind a simple sel/wr peripheral-style access port in test and config subsystems.

---
 rtl/mem_bank_rw.sv | 122 ++++++++++++
 tb/tb_mem_bank_rw.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_rw.sv
// Parametrised single-port register-file memory with byte-lane strobes, a pipelined
// read path (RD_LAT 1 or 2), out-of-range error pulses and a sequential soft-clear engine.
module mem_bank_rw #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sel,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                clr,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                err,
    output logic                busy
);
    localparam int LANES = DATA_W / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    typedef struct packed {
        logic              vld;
        logic              err;
        logic [DATA_W-1:0] data;
    } rd_stage_t;

    state_t                  state, state_nx;
    logic [ADDR_W-1:0]       clr_idx, clr_idx_nx;
    logic                    acc, in_range, wr_acc;
    logic [ADDR_W-1:0]       waddr;
    logic [LANES-1:0]        lane_we;
    logic [LANES-1:0][7:0]   rword;
    rd_stage_t               rd_req;
    rd_stage_t [RD_LAT:1]    rd_pipe;
    logic                    wr_err_q;

    assign busy     = (state == CLEAR);
    // clr has priority over a same-cycle access, so it also blocks acceptance
    assign acc      = sel & ~busy & ~clr;
    assign in_range = 32'(addr) < 32'(DEPTH);
    assign wr_acc   = acc & wr & in_range;
    assign waddr    = busy ? clr_idx : addr;
    assign lane_we  = {LANES{busy}} | ({LANES{wr_acc}} & wstrb);

    for (genvar b = 0; b < LANES; b++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] wbyte, rbyte;

        assign wbyte = busy ? 8'h00 : wdata[8*b +: 8];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
            end else if (lane_we[b]) begin
                for (int e = 0; e < DEPTH; e++)
                    if (waddr == ADDR_W'(e)) mem[e] <= wbyte;
            end
        end

        // no entry matches an out-of-range address, so the read byte falls back to 0
        always_comb begin
            rbyte = '0;
            for (int e = 0; e < DEPTH; e++)
                if (addr == ADDR_W'(e)) rbyte = mem[e];
        end

        assign rword[b] = rbyte;
    end

    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nx   = CLEAR;
                    clr_idx_nx = '0;
                end
            end
            CLEAR: begin
                if (clr_idx == ADDR_W'(DEPTH - 1)) begin
                    state_nx   = IDLE;
                    clr_idx_nx = '0;
                end else begin
                    clr_idx_nx = clr_idx + ADDR_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_req.vld  = acc & ~wr;
        rd_req.err  = acc & ~wr & ~in_range;
        rd_req.data = (acc & ~wr) ? rword : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            clr_idx  <= '0;
            rd_pipe  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state    <= state_nx;
            clr_idx  <= clr_idx_nx;
            wr_err_q <= acc & wr & ~in_range;
            rd_pipe[1] <= rd_req;
            for (int s = 2; s <= RD_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
        end
    end

    assign rvalid = rd_pipe[RD_LAT].vld;
    assign rdata  = rd_pipe[RD_LAT].data;
    assign err    = rd_pipe[RD_LAT].err | wr_err_q;

endmodule

// File: tb/tb_mem_bank_rw.sv
// Bench for mem_bank_rw: two configurations (4 deep / latency 1, 5 deep / latency 2)
// share one stimulus stream and are checked each cycle against a schedule-based model.
module tb_mem_bank_rw;
    logic        clk = 1'b0;
    logic        rstn, sel, wr, clr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  wstrb;

    logic [15:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, err_a, err_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    mem_bank_rw #(.DATA_W(16), .DEPTH(4), .ADDR_W(8), .RD_LAT(1)) dut_a (
        .clk(clk), .rstn(rstn), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .clr(clr), .rdata(rdata_a), .rvalid(rvalid_a), .err(err_a), .busy(busy_a)
    );

    mem_bank_rw #(.DATA_W(16), .DEPTH(5), .ADDR_W(3), .RD_LAT(2)) dut_b (
        .clk(clk), .rstn(rstn), .sel(sel), .wr(wr), .addr(addr[2:0]), .wdata(wdata),
        .wstrb(wstrb), .clr(clr), .rdata(rdata_b), .rvalid(rvalid_b), .err(err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: memory contents, remaining busy cycles, and a short schedule of future outputs
    // (slot 0 = what the outputs must show right after the current edge).
    logic [15:0] mm [2][8];
    logic        sv [2][3];
    logic [15:0] sd [2][3];
    logic        se [2][3];
    int          bl [2];
    int          dep [2] = '{4, 5};
    int          lat [2] = '{1, 2};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int   a;
            logic acc, inr;
            a = (k == 0) ? int'(addr) : int'(addr[2:0]);
            if (!rstn) begin
                for (int e = 0; e < 8; e++) mm[k][e] = 16'h0;
                for (int j = 0; j < 3; j++) begin sv[k][j] = 0; sd[k][j] = 0; se[k][j] = 0; end
                bl[k] = 0;
            end else begin
                acc = sel && (bl[k] == 0) && !clr;
                inr = a < dep[k];
                for (int j = 0; j < 2; j++) begin
                    sv[k][j] = sv[k][j+1]; sd[k][j] = sd[k][j+1]; se[k][j] = se[k][j+1];
                end
                sv[k][2] = 0; sd[k][2] = 0; se[k][2] = 0;
                if (acc && !wr) begin
                    sv[k][lat[k]-1] = 1'b1;
                    sd[k][lat[k]-1] = inr ? mm[k][a] : 16'h0;
                    se[k][lat[k]-1] = !inr;
                end
                if (acc && wr) begin
                    if (inr) begin
                        if (wstrb[0]) mm[k][a][7:0]  = wdata[7:0];
                        if (wstrb[1]) mm[k][a][15:8] = wdata[15:8];
                    end else begin
                        se[k][0] = 1'b1;
                    end
                end
                if (bl[k] > 0) begin
                    mm[k][dep[k] - bl[k]] = 16'h0;
                    bl[k]--;
                end else if (clr) begin
                    bl[k] = dep[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rvalid_a", rvalid_a, sv[0][0]);
            chk("rdata_a",  rdata_a,  sd[0][0]);
            chk("err_a",    err_a,    se[0][0]);
            chk("busy_a",   busy_a,   bl[0] > 0);
            chk("rvalid_b", rvalid_b, sv[1][0]);
            chk("rdata_b",  rdata_b,  sd[1][0]);
            chk("err_b",    err_b,    se[1][0]);
            chk("busy_b",   busy_b,   bl[1] > 0);
        end
    end

    task automatic drive(input logic s, input logic w, input logic [7:0] a,
                         input logic [15:0] d, input logic [1:0] st, input logic c);
        sel = s; wr = w; addr = a; wdata = d; wstrb = st; clr = c;
        @(posedge clk); #1;
        sel = 0; wr = 0; clr = 0; wstrb = 0;
    endtask

    task automatic wrt(input logic [7:0] a, input logic [15:0] d, input logic [1:0] st);
        drive(1'b1, 1'b1, a, d, st, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        drive(1'b1, 1'b0, a, 16'h0, 2'b00, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int cnt_a, cnt_b;
        rstn = 0; sel = 0; wr = 0; clr = 0; addr = 0; wdata = 0; wstrb = 0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rstn = 1;
        chk("rst_rvalid_a", rvalid_a, 0);
        chk("rst_busy_b", busy_b, 0);

        // reads of a freshly reset memory
        rd(0);
        chk("rd0_rvalid_a", rvalid_a, 1);
        chk("rd0_rdata_a", rdata_a, 16'h0000);
        for (int i = 1; i < 4; i++) rd(8'(i));
        idle(2);

        // lane merge and read-after-write
        wrt(2, 16'hABCD, 2'b11);
        wrt(2, 16'h1234, 2'b01);
        rd(2);
        chk("raw_rvalid_a", rvalid_a, 1);
        chk("raw_rdata_a", rdata_a, 16'hAB34);
        idle(1);
        chk("raw_rdata_b", rdata_b, 16'hAB34);
        wrt(2, 16'hFFFF, 2'b00);
        rd(2);
        idle(2);

        // back-to-back reads, latency 2 ordering
        wrt(0, 16'h0011, 2'b11);
        wrt(1, 16'h0022, 2'b11);
        wrt(2, 16'h0033, 2'b11);
        wrt(3, 16'h0044, 2'b11);
        rd(0);
        chk("lat2_first_b", rvalid_b, 0);
        rd(1);
        chk("lat2_d0_b", rdata_b, 16'h0011);
        rd(2);
        chk("lat2_d1_b", rdata_b, 16'h0022);
        rd(3);
        chk("lat2_d2_b", rdata_b, 16'h0033);
        idle(1);
        chk("lat2_d3_b", rdata_b, 16'h0044);
        chk("lat2_v3_b", rvalid_b, 1);
        idle(1);
        chk("lat2_end_b", rvalid_b, 0);

        // out-of-range accesses
        wrt(6, 16'hBEEF, 2'b11);
        chk("oob_wr_err_a", err_a, 1);
        chk("oob_wr_err_b", err_b, 1);
        rd(6);
        chk("oob_rd_err_a", err_a, 1);
        chk("oob_rd_rvalid_a", rvalid_a, 1);
        chk("oob_rd_rdata_a", rdata_a, 16'h0000);
        idle(1);
        chk("oob_rd_err_b", err_b, 1);
        chk("oob_rd_rvalid_b", rvalid_b, 1);
        chk("oob_rd_rdata_b", rdata_b, 16'h0000);
        wrt(4, 16'h4444, 2'b11);
        rd(4);
        wrt(12, 16'h5555, 2'b11);
        rd(4);
        idle(3);

        // soft clear with same-cycle write, ignored clr and accesses while busy
        for (int i = 0; i < 5; i++) wrt(8'(i), 16'(16'h1111 * i + 16'h0101), 2'b11);
        rd(1);
        drive(1'b1, 1'b1, 8'd0, 16'hFFFF, 2'b11, 1'b1);
        chk("preclr_rdata_b", rdata_b, 16'h1212);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            cnt_a += int'(busy_a);
            cnt_b += int'(busy_b);
            drive(1'b1, 1'b0, 8'(i % 5), 16'h0, 2'b00, i == 2);
        end
        chk("busy_cnt_a", cnt_a, 4);
        chk("busy_cnt_b", cnt_b, 5);
        for (int i = 0; i < 5; i++) rd(8'(i));
        idle(3);

        // reset during clear with a latency-2 read in flight
        for (int i = 0; i < 5; i++) wrt(8'(i), 16'hC3C3, 2'b11);
        rd(3);
        drive(1'b0, 1'b0, 8'd0, 16'h0, 2'b00, 1'b1);
        rstn = 0;
        @(posedge clk); #1;
        chk("rstclr_busy_a", busy_a, 0);
        chk("rstclr_busy_b", busy_b, 0);
        chk("rstclr_rvalid_b", rvalid_b, 0);
        chk("rstclr_rdata_b", rdata_b, 16'h0000);
        chk("rstclr_err_b", err_b, 0);
        rstn = 1;
        for (int i = 0; i < 5; i++) rd(8'(i));
        idle(3);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
